// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Size encodings, FSM states and the misalignment helper live here.
package dmem_lsu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [1:0] size_t;

  localparam size_t SZ_B = 2'b00;
  localparam size_t SZ_H = 2'b01;
  localparam size_t SZ_W = 2'b10;
  localparam size_t SZ_X = 2'b11;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StResp
  } state_e;

  // True when the low address bits do not match the natural alignment of the size.
  function automatic logic misaligned(input size_t size, input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    case (size)
      SZ_H:    res = addr_lo[0];
      SZ_W:    res = |addr_lo;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane merge for stores and lane select plus sign/zero extension for loads.
// Purely combinational; the caller guarantees alignment before using the results.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  size_t             size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Selecting the lane directly is the aligned equivalent of shifting by 8*addr_lo.
  assign byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = mem_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    merged    = mem_word;
    load_data = mem_word;
    case (size)
      SZ_B: begin
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        merged    = wdata;
        load_data = mem_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-port data memory with a load/store request/response interface.
// After reset the array is initialised one word per cycle before requests are accepted.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter logic [DATA_W-1:0] KEY_VALUE = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W-1:0] idx_t;

  state_e            state_q, state_d;
  idx_t              idx_q, idx_d;
  logic              init_done_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              idx_last;
  logic              out_of_range;
  logic              req_err;
  idx_t              widx;
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_data;

  assign accept   = req_valid & req_ready;
  assign idx_last = (idx_q == idx_t'(DEPTH - 1));
  assign widx     = req_addr[IDX_W+1:2];
  assign mem_word = mem[widx];

  // Any word index beyond the array faults, so the truncated index never aliases.
  assign out_of_range = (req_addr[ADDR_W-1:2] > (ADDR_W - 2)'(DEPTH - 1));
  assign req_err      = (req_size == SZ_X) | misaligned(req_size, req_addr[1:0]) | out_of_range;

  dmem_lane_align u_lane_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .addr_lo     (req_addr[1:0]),
    .mem_word    (mem_word),
    .wdata       (req_wdata),
    .merged      (merged),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (idx_last) state_d = StIdle;
      StIdle:  if (req_valid) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  assign idx_d = (state_q == StInit) ? idx_q + idx_t'(1) : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      init_done_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      idx_q <= idx_d;
      if (state_q == StInit && idx_last) begin
        init_done_q <= 1'b1;
      end
      if (accept) begin
        rsp_err_q   <= req_err;
        rsp_rdata_q <= (!req_we && !req_err) ? load_data : '0;
      end
    end
  end

  // No reset on the array: contents are defined only by the init sweep.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[idx_q] <= (idx_q == '0) ? KEY_VALUE : '0;
    end else if (accept && req_we && !req_err) begin
      mem[widx] <= merged;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule
